// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: output-register FSM
// encoding and the round-robin choice function.
package mux_arbiter_pkg;

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    typedef enum logic {
        ST_EMPTY = EMPTY,
        ST_FULL  = FULL
    } out_state_t;

    // With no request the previous grant is kept so sel does not toggle idly.
    function automatic logic rr_choice(
        input logic valid0,
        input logic valid1,
        input logic last_grant
    );
        logic choice;
        choice = last_grant;
        if (valid0 && !valid1) begin
            choice = 1'b0;
        end else if (!valid0 && valid1) begin
            choice = 1'b1;
        end else if (valid0 && valid1) begin
            choice = ~last_grant;
        end
        return choice;
    endfunction

endpackage

// File: rtl/mux_arbiter_multiplexor.sv
// Plain 2:1 word multiplexor shared by the arbiter's two requesters.
module multiplexor #(
    parameter int WIDTH = 5
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] mux_out
);

    assign mux_out = sel ? in1 : in0;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one 2:1 multiplexor between two valid/ready
// requesters, feeding a single one-word registered output channel.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel
);

    out_state_t       state_p1;
    logic             last_grant;
    logic [WIDTH-1:0] data_p1;
    logic [WIDTH-1:0] mux_out_p0;
    logic             load_ok;
    logic             choice;
    logic             take0;
    logic             take1;

    assign load_ok = (state_p1 == ST_EMPTY) || out_ready;
    assign choice  = rr_choice(req0_valid, req1_valid, last_grant);
    assign sel     = load_ok ? choice : last_grant;

    // Readys are masked during reset so no handshake completes on a reset edge.
    assign req0_ready = !rst && load_ok && req0_valid && (sel == 1'b0);
    assign req1_ready = !rst && load_ok && req1_valid && (sel == 1'b1);

    assign take0 = req0_valid && req0_ready;
    assign take1 = req1_valid && req1_ready;

    multiplexor #(
        .WIDTH(WIDTH)
    ) u_mux (
        .sel    (sel),
        .in0    (req0_data),
        .in1    (req1_data),
        .mux_out(mux_out_p0)
    );

    // p0 -> p1: output register and FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1   <= ST_EMPTY;
            data_p1    <= '0;
            last_grant <= 1'b1;
        end else if (take0 || take1) begin
            state_p1   <= ST_FULL;
            data_p1    <= mux_out_p0;
            last_grant <= sel;
        end else if (state_p1 == ST_FULL && out_ready) begin
            state_p1   <= ST_EMPTY;
        end
    end

    assign out_valid = (state_p1 == ST_FULL);
    assign out_data  = data_p1;

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares one 2:1 `multiplexor` datapath between two requesters and drives a single output channel. Each requester and the output use a valid/ready handshake. The block owns the mux select and a one-word output register, so downstream logic sees one registered stream. It sits between two producer blocks and one consumer in lab-level datapaths.

## Interface
- `WIDTH`, default 5: data width of both requesters and the output.

- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `req0_valid`  input  1  requester 0 has a word.
- `req0_data`  input  WIDTH  requester 0 word.
- `req0_ready`  output  1  requester 0 word is accepted this cycle.
- `req1_valid`  input  1  requester 1 has a word.
- `req1_data`  input  WIDTH  requester 1 word.
- `req1_ready`  output  1  requester 1 word is accepted this cycle.
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  WIDTH  output register contents.
- `out_ready`  input  1  consumer takes the word this cycle.
- `sel`  output  1  current mux select, the same signal that drives the `multiplexor`.

## Operation
- Output register FSM has two states, encoded EMPTY=0 and FULL=1. `out_valid` is 1 exactly when the state is FULL.
- `load_ok` = EMPTY, or (FULL and `out_ready`).
- `last_grant` is a 1-bit register; it resets to 1, so requester 0 wins the first tie.
- Choice:
  - Only req0 valid: 0.
  - Only req1 valid: 1.
  - Both valid: `~last_grant`.
  - Neither valid: `last_grant`.
- `sel` = choice when `load_ok`, otherwise `last_grant`.
- `reqN_ready` = `load_ok` and `reqN_valid` and (`sel`==N). At most one ready is high in any cycle.
- A transfer occurs when `reqN_valid` and `reqN_ready` are both high. On that edge:
  - `out_data` takes the mux output.
  - State becomes FULL.
  - `last_grant` takes N.
- FULL, `out_ready`=1, no request: state becomes EMPTY; `out_data` holds its stale value.
- FULL, `out_ready`=1, request present: drain and load in the same cycle; state stays FULL.
- FULL, `out_ready`=0: hold. Both readys are 0; `out_data` and `last_grant` are stable.
- Arbitration is work-conserving. A lone requester is granted every cycle, even if it won last time.
- Requesters may drop valid at any time. No grant is reserved or latched across cycles.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, FSM=EMPTY, `last_grant`=1.
- During any cycle with `rst`=1, `req0_ready`=0 and `req1_ready`=0.
- Reset mid-operation discards the buffered word; no handshake completes on that edge.
- Latency is 1 cycle: a word accepted at edge k is on `out_data` with `out_valid`=1 after edge k.
- Throughput is 1 word per cycle while `out_ready`=1.
- Readys depend combinationally on `out_ready`, `req0_valid` and `req1_valid`.
- Readys never depend combinationally on `reqN_data`.
- Simultaneous drain and load never produce a bubble.
- Fairness bound: under continuous contention with `out_ready`=1, each requester is served every 2nd cycle.

## Structure
- Shared package/include holds the FSM state localparams EMPTY and FULL.
- Instantiate the existing `multiplexor` (parameter `WIDTH`, ports `sel`, `in0`, `in1`, `mux_out`) as the only sub-module:
  - `sel` ← arbiter `sel`
  - `in0` ← `req0_data`
  - `in1` ← `req1_data`
  - `mux_out` feeds the `out_data` register.
- Arbiter logic, FSM and output register live in `mux_arbiter`.

## Test plan
All scenarios use `WIDTH`=5.
- Reset: hold `rst`=1 for 2 cycles with both valids high -> both readys 0 throughout; after release `out_valid`=0, `out_data`=5'h00, `sel`=1.
- Single requester: `req0_valid`=1, `req0_data`=5'h15, `out_ready`=1 -> `req0_ready`=1 and `sel`=0 in that cycle; next cycle `out_valid`=1, `out_data`=5'h15.
- Contention: both valid continuously, `req0_data`=5'h15, `req1_data`=5'h0A, `out_ready`=1 -> `out_data` sequence 15,0A,15,0A… starting 1 cycle after release from reset; no bubbles.
- Backpressure: FULL with 5'h15, `out_ready`=0 for 3 cycles with both valid -> both readys 0, `out_data`=5'h15 stable; raise `out_ready` -> req1 word 5'h0A loads that same edge.
- Work-conserving: req1 alone valid for 3 cycles (`req1_data`=5'h0A) -> `req1_ready`=1 each cycle, 3 outputs of 5'h0A; then both valid -> req0 wins next.
- Reset mid-operation: FULL with 5'h0A, `out_ready`=0, assert `rst` one cycle -> next cycle `out_valid`=0, `out_data`=5'h00; with both valid after release, req0 is granted first.
